// File: rtl/dnn_sample_feeder_pkg.sv
// Shared definitions for the DNN sample feeder: default geometry, width helpers
// and the sample record carried through the input buffers.
package dnn_sample_feeder_pkg;

  function automatic int calc_cpc(input int n_in, input int acts_per_clk);
    return n_in / acts_per_clk + 2;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int clog2_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int SF_WIDTH        = 10;
  localparam int SF_WIDTH_IN     = 8;
  localparam int SF_N_IN         = 64;
  localparam int SF_N_OUT        = 4;
  localparam int SF_ACTS_PER_CLK = 16;
  localparam int SF_YS_PER_CLK   = 1;
  localparam int SF_L            = 3;
  localparam int SF_CNT_WIDTH    = 32;
  localparam int SF_LABEL_W      = clog2_w(SF_N_OUT);

  typedef struct packed {
    logic [SF_N_IN*SF_WIDTH_IN-1:0] act;
    logic [SF_LABEL_W-1:0]          label;
    logic [SF_WIDTH-1:0]            eta;
  } sample_t;

endpackage

// File: rtl/dnn_sample_feeder_label_pipe.sv
// Depth-L delay line of {label, valid}, advanced once per block cycle so the
// label of a streamed sample lines up with the DNN decision it produces.
module dnn_label_pipe
  import dnn_sample_feeder_pkg::*;
#(
  parameter int DEPTH = SF_L,
  parameter int LBL_W = SF_LABEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [LBL_W-1:0] in_label,
  input  logic             in_vld,
  output logic [LBL_W-1:0] tail_label,
  output logic             tail_vld
);

  logic [LBL_W-1:0] lbl_p [DEPTH];
  logic [DEPTH-1:0] vld_p;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_p <= '0;
    end else if (en) begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      lbl_p[0] <= in_label;
      for (int i = 1; i < DEPTH; i++) lbl_p[i] <= lbl_p[i-1];
    end
  end

  assign tail_label = lbl_p[DEPTH-1];
  assign tail_vld   = vld_p[DEPTH-1];

endmodule

// File: rtl/dnn_sample_feeder.sv
// Training-sample source/sink for the DNN: double-buffers whole samples, streams
// them in per-clock chunks on a mirrored block counter and scores the decisions.
module dnn_sample_feeder
  import dnn_sample_feeder_pkg::*;
#(
  parameter int width        = SF_WIDTH,
  parameter int width_in     = SF_WIDTH_IN,
  parameter int n_in         = SF_N_IN,
  parameter int n_out        = SF_N_OUT,
  parameter int acts_per_clk = SF_ACTS_PER_CLK,
  parameter int ys_per_clk   = SF_YS_PER_CLK,
  parameter int cpc          = calc_cpc(n_in, acts_per_clk),
  parameter int L            = SF_L,
  parameter int cnt_width    = SF_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [n_in*width_in-1:0]         s_act,
  input  logic [clog2_w(n_out)-1:0]        s_label,
  input  logic [width-1:0]                 s_eta,
  output logic [width_in*acts_per_clk-1:0] a_in,
  output logic [ys_per_clk-1:0]            y_in,
  output logic [width-1:0]                 eta_in,
  input  logic [n_out-1:0]                 dnn_a_out_alln,
  output logic                             res_valid,
  output logic                             res_correct,
  output logic [cnt_width-1:0]             total_cnt,
  output logic [cnt_width-1:0]             correct_cnt
);

  localparam int ACT_W   = n_in * width_in;
  localparam int LBL_W   = clog2_w(n_out);
  localparam int CHUNK_W = width_in * acts_per_clk;
  localparam int NCHUNK  = cpc - 2;
  localparam int YW      = NCHUNK * ys_per_clk;
  localparam int CNT_W   = clog2_w(cpc);

  typedef struct packed {
    logic [ACT_W-1:0] act;
    logic [LBL_W-1:0] label;
    logic [width-1:0] eta;
  } rec_t;

  function automatic logic [cnt_width-1:0] sat_inc(input logic [cnt_width-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               boundary, xfer, load;
  logic               hold_full, act_valid, vld_nxt;
  rec_t               hold_p0, act_p1, act_nxt;
  logic [YW-1:0]      onehot;
  logic [CHUNK_W-1:0] a_nxt;
  logic [ys_per_clk-1:0] y_nxt;
  logic [width-1:0]   eta_nxt;
  logic [LBL_W-1:0]   tail_label;
  logic               tail_vld, score, hit;

  assign boundary = (cnt == CNT_W'(cpc - 1));
  assign s_ready  = reset & ~hold_full;
  assign xfer     = s_valid & s_ready;
  assign load     = boundary & hold_full;
  assign score    = (cnt == CNT_W'(1)) & tail_vld;

  // Outputs are registered from next-state values so chunk k is on a_in
  // exactly while the DNN's cycle index reads k.
  always_comb begin
    cnt_nxt = boundary ? '0 : cnt + 1'b1;
    act_nxt = load ? hold_p0 : act_p1;
    vld_nxt = boundary ? hold_full : act_valid;
    onehot  = '0;
    for (int k = 0; k < YW; k++) onehot[k] = (int'(act_nxt.label) == k);
    a_nxt   = '0;
    y_nxt   = '0;
    eta_nxt = '0;
    if (vld_nxt) begin
      eta_nxt = act_nxt.eta;
      for (int k = 0; k < NCHUNK; k++) begin
        if (int'(cnt_nxt) == k) begin
          a_nxt = act_nxt.act[k*CHUNK_W +: CHUNK_W];
          y_nxt = onehot[k*ys_per_clk +: ys_per_clk];
        end
      end
    end
    hit = 1'b0;
    for (int k = 0; k < n_out; k++) begin
      if (int'(tail_label) == k) hit = dnn_a_out_alln[k];
    end
  end

  // Stage p0 holding buffer -> stage p1 active buffer at the block boundary
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt         <= '0;
      hold_full   <= 1'b0;
      act_valid   <= 1'b0;
      a_in        <= '0;
      y_in        <= '0;
      eta_in      <= '0;
      res_valid   <= 1'b0;
      res_correct <= 1'b0;
      total_cnt   <= '0;
      correct_cnt <= '0;
    end else begin
      cnt       <= cnt_nxt;
      act_valid <= vld_nxt;
      if (boundary) hold_full <= 1'b0;
      if (xfer)     hold_full <= 1'b1;
      a_in        <= a_nxt;
      y_in        <= y_nxt;
      eta_in      <= eta_nxt;
      res_valid   <= score;
      res_correct <= score & hit;
      if (score) begin
        total_cnt <= sat_inc(total_cnt);
        if (hit) correct_cnt <= sat_inc(correct_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) hold_p0 <= '{act: s_act, label: s_label, eta: s_eta};
    if (load) act_p1  <= hold_p0;
  end

  // Labels ride alongside the network's L-block latency
  dnn_label_pipe #(
    .DEPTH (L),
    .LBL_W (LBL_W)
  ) u_label_pipe (
    .clk        (clk),
    .reset      (reset),
    .en         (boundary),
    .in_label   (hold_p0.label),
    .in_vld     (hold_full),
    .tail_label (tail_label),
    .tail_vld   (tail_vld)
  );

endmodule

// File: tb/tb_dnn_sample_feeder.sv
// Bench for dnn_sample_feeder: a queue-based block-level reference model plus a
// table of labelled samples with hand-derived scoring outcomes.
module tb_dnn_sample_feeder;

  localparam int WIDTH = 10, WIDTH_IN = 8, N_IN = 64, N_OUT = 4;
  localparam int APC = 16, YPC = 1, CPC = 6, L = 3, CW = 4;
  localparam int LBL_W = $clog2(N_OUT);
  localparam int ACT_W = N_IN * WIDTH_IN;
  localparam int CH_W  = WIDTH_IN * APC;
  localparam int SAT   = (1 << CW) - 1;
  localparam int NTAB  = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [ACT_W-1:0] s_act = '0;
  logic [LBL_W-1:0] s_label = '0;
  logic [WIDTH-1:0] s_eta = '0;
  logic [CH_W-1:0]  a_in;
  logic [YPC-1:0]   y_in;
  logic [WIDTH-1:0] eta_in;
  logic [N_OUT-1:0] alln = '0;
  logic res_valid, res_correct;
  logic [CW-1:0] total_cnt, correct_cnt;

  dnn_sample_feeder #(
    .width(WIDTH), .width_in(WIDTH_IN), .n_in(N_IN), .n_out(N_OUT),
    .acts_per_clk(APC), .ys_per_clk(YPC), .cpc(CPC), .L(L), .cnt_width(CW)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_act(s_act), .s_label(s_label), .s_eta(s_eta),
    .a_in(a_in), .y_in(y_in), .eta_in(eta_in), .dnn_a_out_alln(alln),
    .res_valid(res_valid), .res_correct(res_correct),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; logic [ACT_W-1:0] act; int label; int eta; int id; } rec_t;
  typedef struct { int label; int eta; logic [N_OUT-1:0] alln; bit exp_correct; } tab_t;

  tab_t tab [NTAB];
  int vectors = 0, miscompares = 0;
  rec_t holdq[$], hist[$], cur;
  int ph = 0, tot = 0, cor = 0, scored_id = -1, cur_id = -1;
  bit e_rv = 0, e_rc = 0, last_xfer = 0, cap_eta = 0;
  int seen_eta[$];
  logic [ACT_W-1:0] ramp;

  function automatic rec_t no_rec();
    rec_t r;
    r.v = 0; r.act = '0; r.label = 0; r.eta = 0; r.id = -1;
    return r;
  endfunction

  function automatic logic [ACT_W-1:0] rand_act();
    logic [ACT_W-1:0] v;
    for (int w = 0; w < ACT_W / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [CH_W-1:0] got, input logic [CH_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Advance the model by one clock from the currently driven inputs, then
  // clock the DUT and compare every output.
  task automatic step();
    rec_t r;
    logic [CH_W-1:0] ea;
    logic [YPC-1:0] ey;
    int ee;
    bit bnd, xfer;
    last_xfer = 0;
    if (!reset) begin
      ph = 0; holdq.delete(); hist.delete(); cur = no_rec();
      tot = 0; cor = 0; e_rv = 0; e_rc = 0;
    end else begin
      bnd  = (ph == CPC - 1);
      xfer = s_valid && (holdq.size() == 0);
      e_rv = (ph == 1) && (hist.size() == L) && hist[0].v;
      e_rc = 0;
      if (e_rv) begin
        e_rc = alln[hist[0].label];
        scored_id = hist[0].id;
        if (tot < SAT) tot++;
        if (e_rc && cor < SAT) cor++;
      end
      if (bnd) begin
        if (holdq.size() > 0) r = holdq.pop_front();
        else r = no_rec();
        cur = r;
        hist.push_back(r);
        if (hist.size() > L) void'(hist.pop_front());
      end
      if (xfer) begin
        r.v = 1; r.act = s_act; r.label = int'(s_label); r.eta = int'(s_eta); r.id = cur_id;
        holdq.push_back(r);
        last_xfer = 1;
      end
      ph = (ph + 1) % CPC;
    end
    @(posedge clk);
    #1;
    ea = '0; ey = '0; ee = 0;
    if (cur.v) begin
      ee = cur.eta;
      if (ph < CPC - 2) begin
        ea = cur.act[ph*CH_W +: CH_W];
        for (int j = 0; j < YPC; j++) ey[j] = (cur.label == ph * YPC + j);
      end
    end
    chk("a_in", a_in, ea);
    chk("y_in", y_in, ey);
    chk("eta_in", eta_in, ee);
    chk("s_ready", s_ready, reset && (holdq.size() == 0));
    chk("res_valid", res_valid, e_rv);
    chk("res_correct", res_correct, e_rc);
    chk("total_cnt", total_cnt, tot);
    chk("correct_cnt", correct_cnt, cor);
    if (e_rv && scored_id >= 0 && scored_id < NTAB)
      chk("tab_correct", res_correct, tab[scored_id].exp_correct);
    if (cur.v && cur.id == 0 && ph < CPC - 2) begin
      chk("ramp_byte0", a_in[7:0], ph * 16);
      chk("ramp_y", y_in, ph == 2);
      chk("ramp_eta", eta_in, 5);
    end
    if (cap_eta && cur.v && ph == 0) seen_eta.push_back(int'(eta_in));
  endtask

  // Present the decision a table sample is scored against while it sits at the tail.
  task automatic tab_alln();
    if (hist.size() == L && hist[0].v && hist[0].id >= 0 && hist[0].id < NTAB)
      alln = tab[hist[0].id].alln;
  endtask

  task automatic offer(input logic [ACT_W-1:0] act, input int label, input int eta,
                       input int id, input bit use_tab);
    int guard = 0;
    s_valid = 1'b1; s_act = act; s_label = LBL_W'(label); s_eta = WIDTH'(eta); cur_id = id;
    do begin
      if (use_tab) tab_alln();
      step();
      guard++;
    end while (!last_xfer && guard < 4 * CPC);
    chk("accept", last_xfer, 1'b1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < N_IN; i++) ramp[i*WIDTH_IN +: WIDTH_IN] = WIDTH_IN'(i);
    tab[0] = '{2, 5,    4'b0100, 1'b1};
    tab[1] = '{1, 7,    4'b1000, 1'b0};
    tab[2] = '{0, 1,    4'b0001, 1'b1};
    tab[3] = '{3, 1023, 4'b1000, 1'b1};
    tab[4] = '{3, 2,    4'b0111, 1'b0};
    tab[5] = '{1, 0,    4'b0010, 1'b1};

    reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;

    // Back-to-back table samples, s_valid held high throughout
    for (int i = 0; i < NTAB; i++)
      offer((i == 0) ? ramp : rand_act(), tab[i].label, tab[i].eta, i, 1'b1);
    s_valid = 1'b0;
    repeat ((L + 2) * CPC) begin tab_alln(); step(); end
    chk("tab_total", total_cnt, 6);
    chk("tab_correct_cnt", correct_cnt, 4);

    // Starvation: bubbles only, nothing scored
    repeat ((2 + L) * CPC) begin alln = N_OUT'($urandom); step(); end
    chk("starve_total", total_cnt, 6);

    // Second sample offered while the holding buffer is full across a boundary
    cap_eta = 1'b1;
    seen_eta.delete();
    offer(rand_act(), 1, 11, 200, 1'b0);
    offer(rand_act(), 3, 22, 201, 1'b0);
    s_valid = 1'b0;
    repeat (3 * CPC) step();
    cap_eta = 1'b0;
    chk("order_count", seen_eta.size(), 2);
    chk("order_first", (seen_eta.size() > 0) ? seen_eta[0] : -1, 11);
    chk("order_second", (seen_eta.size() > 1) ? seen_eta[1] : -1, 22);

    // Reset with samples in flight
    offer(rand_act(), 0, 33, 300, 1'b0);
    offer(rand_act(), 2, 44, 301, 1'b0);
    s_valid = 1'b0;
    repeat (CPC + 2) step();
    reset = 1'b0;
    repeat (2) step();
    chk("rst_total", total_cnt, 0);
    reset = 1'b1;
    alln = '1;
    offer(rand_act(), 3, 55, 302, 1'b0);
    s_valid = 1'b0;
    seen = 0;
    repeat ((L + 2) * CPC) begin step(); if (res_valid) seen++; end
    chk("post_rst_scored", seen, 1);

    // Randomized traffic, decisions and occasional resets; counters saturate
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 499) != 0);
      if (!s_valid || last_xfer) begin
        s_valid = $urandom_range(0, 3) != 0;
        s_act   = rand_act();
        s_label = LBL_W'($urandom);
        s_eta   = WIDTH'($urandom);
        cur_id  = 1000 + i;
      end
      alln = N_OUT'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
